// File: rtl/coax_rx_if.sv
// Signal bundle between the coax line/transmitter side and the coax_rx receiver.
// The master drives the line and the transmitter-busy flag; the slave reports decoded words.
interface coax_rx_if;
    logic       rx;
    logic       tx_active;
    logic       active;
    logic [9:0] data;
    logic       strobe;
    logic       error;
    logic [1:0] error_code;

    modport master (
        output rx, tx_active,
        input  active, data, strobe, error, error_code
    );

    modport slave (
        input  rx, tx_active,
        output active, data, strobe, error, error_code
    );
endinterface

// File: rtl/coax_rx.sv
// 3270 coax Manchester receiver: hunts for quiesce ones plus code violation, then
// decodes sync + 10 data + parity words into strobed 10-bit words.
module coax_rx #(
    parameter int unsigned CLOCKS_PER_BIT = 8
) (
    input  logic     clk,
    input  logic     reset_n,
    coax_rx_if.slave bus
);
    localparam int unsigned T     = CLOCKS_PER_BIT;
    localparam int unsigned W     = T / 4;
    localparam int unsigned E_MAX = 2 * T;
    localparam int unsigned EW    = $clog2(E_MAX + 1);

    localparam logic [EW-1:0] WIN_LO = EW'(T - W);
    localparam logic [EW-1:0] WIN_HI = EW'(T + W);
    localparam logic [EW-1:0] CV_LO  = EW'((3 * T) / 2 - W);
    localparam logic [EW-1:0] CV_HI  = EW'((3 * T) / 2 + W);
    localparam logic [EW-1:0] E_SAT  = EW'(E_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CV_HIGH,
        S_CV_LOW,
        S_DATA,
        S_PARITY,
        S_SYNC
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic          r_rx_meta;
    logic          r_rx_sync;
    logic          r_rx_prev;
    logic [EW-1:0] r_ecnt;
    logic [2:0]    r_ones;
    logic [3:0]    r_bitcnt;
    logic [9:0]    r_shift;
    logic [9:0]    r_data;
    logic          r_strobe;
    logic          r_error;
    logic [1:0]    r_code;
    logic          r_active;

    logic          w_edge;
    logic          w_rise;
    logic          w_in_win;
    logic          w_in_cv;
    logic          w_late;
    logic          w_par_ok;
    logic [EW-1:0] w_ecnt_nxt;
    logic [2:0]    w_ones_nxt;
    logic [3:0]    w_bitcnt_nxt;
    logic [9:0]    w_shift_nxt;
    logic [9:0]    w_data_nxt;
    logic          w_strobe_nxt;
    logic          w_error_nxt;
    logic [1:0]    w_code_nxt;
    logic          w_active_nxt;

    assign w_edge   = r_rx_sync ^ r_rx_prev;
    assign w_rise   = r_rx_sync & ~r_rx_prev;
    assign w_in_win = (r_ecnt >= WIN_LO) && (r_ecnt <= WIN_HI);
    assign w_in_cv  = (r_ecnt >= CV_LO) && (r_ecnt <= CV_HI);
    assign w_late   = (r_ecnt > WIN_HI);
    assign w_par_ok = ~^{r_shift, w_rise};

    always_comb begin
        w_state_nxt  = r_state;
        w_ecnt_nxt   = (r_ecnt == E_SAT) ? r_ecnt : r_ecnt + EW'(1);
        w_ones_nxt   = r_ones;
        w_bitcnt_nxt = r_bitcnt;
        w_shift_nxt  = r_shift;
        w_data_nxt   = r_data;
        w_strobe_nxt = 1'b0;
        w_error_nxt  = 1'b0;
        w_code_nxt   = r_code;

        // E is reloaded with 1 on an accepted edge so it reads "cycles since edge".
        if (bus.tx_active) begin
            w_state_nxt = S_IDLE;
            w_ones_nxt  = '0;
            w_ecnt_nxt  = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if ((r_ones == 3'd5) && w_late) begin
                        if (!w_edge) begin
                            w_state_nxt = S_CV_HIGH;
                        end else begin
                            w_ecnt_nxt = EW'(1);
                            if (!w_rise && (r_ecnt <= CV_HI)) w_state_nxt = S_CV_LOW;
                            else                              w_ones_nxt  = '0;
                        end
                    end else if (w_edge && (r_ecnt >= WIN_LO)) begin
                        w_ecnt_nxt = EW'(1);
                        if (w_in_win)
                            w_ones_nxt = !w_rise ? 3'd0 :
                                         (r_ones == 3'd5) ? 3'd5 : r_ones + 3'd1;
                        else
                            // a rise after a quiet line opens a fresh run of ones
                            w_ones_nxt = w_rise ? 3'd1 : 3'd0;
                    end else if (r_ecnt > CV_HI) begin
                        w_ones_nxt = '0;
                    end
                end

                S_CV_HIGH, S_CV_LOW: begin
                    if (w_edge) begin
                        w_ecnt_nxt = EW'(1);
                        if (w_in_cv && (w_rise == (r_state == S_CV_LOW))) begin
                            w_state_nxt  = (r_state == S_CV_HIGH) ? S_CV_LOW : S_DATA;
                            w_bitcnt_nxt = '0;
                        end else begin
                            w_state_nxt = S_IDLE;
                            w_ones_nxt  = '0;
                        end
                    end else if (r_ecnt > CV_HI) begin
                        w_state_nxt = S_IDLE;
                        w_ones_nxt  = '0;
                    end
                end

                S_DATA, S_PARITY, S_SYNC: begin
                    if (w_edge && w_in_win) begin
                        w_ecnt_nxt = EW'(1);
                        if (r_state == S_DATA) begin
                            w_shift_nxt  = {r_shift[8:0], w_rise};
                            w_bitcnt_nxt = r_bitcnt + 4'd1;
                            if (r_bitcnt == 4'd9) w_state_nxt = S_PARITY;
                        end else if (r_state == S_PARITY) begin
                            w_state_nxt = S_SYNC;
                            if (w_par_ok) begin
                                w_strobe_nxt = 1'b1;
                                w_data_nxt   = r_shift;
                            end else begin
                                w_error_nxt = 1'b1;
                                w_code_nxt  = 2'b01;
                            end
                        end else if (w_rise) begin
                            w_state_nxt  = S_DATA;
                            w_bitcnt_nxt = '0;
                        end else begin
                            w_state_nxt = S_IDLE;
                            w_ones_nxt  = '0;
                        end
                    end else if (w_late) begin
                        w_state_nxt = S_IDLE;
                        w_ones_nxt  = '0;
                        w_error_nxt = 1'b1;
                        w_code_nxt  = 2'b10;
                    end
                end

                default: begin
                    w_state_nxt = S_IDLE;
                    w_ones_nxt  = '0;
                end
            endcase
        end

        w_active_nxt = (w_state_nxt == S_DATA) || (w_state_nxt == S_PARITY) ||
                       (w_state_nxt == S_SYNC);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_meta <= 1'b0;
            r_rx_sync <= 1'b0;
            r_rx_prev <= 1'b0;
        end else begin
            r_rx_meta <= bus.rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_ecnt   <= '0;
            r_ones   <= '0;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_data   <= '0;
            r_strobe <= 1'b0;
            r_error  <= 1'b0;
            r_code   <= '0;
            r_active <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_ecnt   <= w_ecnt_nxt;
            r_ones   <= w_ones_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_shift  <= w_shift_nxt;
            r_data   <= w_data_nxt;
            r_strobe <= w_strobe_nxt;
            r_error  <= w_error_nxt;
            r_code   <= w_code_nxt;
            r_active <= w_active_nxt;
        end
    end

    assign bus.active     = r_active;
    assign bus.data       = r_data;
    assign bus.strobe     = r_strobe;
    assign bus.error      = r_error;
    assign bus.error_code = r_code;
endmodule
